// File: rtl/tree_mac_job_scheduler.sv
// Job sequencer for the pipelined tree MAC: walks a tile's (i,k) indices under result-buffer credits.
// Optional stall-cycle counter enabled by defining TREE_MAC_SCHED_STALL_CNT_EN.
module tree_mac_job_scheduler #(
  parameter int ADDRESS_WIDTH_I = 8,
  parameter int ADDRESS_WIDTH_K = 8,
  parameter int CREDIT_DEPTH    = 8,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDRESS_WIDTH_I-1:0] cfg_num_i,
  input  logic [ADDRESS_WIDTH_K-1:0] cfg_num_k,
  output logic                       busy,
  output logic                       done,
  output logic                       issue_val,
  output logic [ADDRESS_WIDTH_I-1:0] issue_addr_i,
  output logic [ADDRESS_WIDTH_K-1:0] issue_addr_k,
  input  logic                       mac_val_out,
  input  logic                       credit_return,
  output logic                       credit_err
`ifdef TREE_MAC_SCHED_STALL_CNT_EN
  ,
  output logic [STALL_CNT_WIDTH-1:0] stall_cycles
`endif
);

  localparam int CW = $clog2(CREDIT_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  if (CREDIT_DEPTH < 1 || STALL_CNT_WIDTH < 1) begin : g_param_check
    $error("tree_mac_job_scheduler: CREDIT_DEPTH and STALL_CNT_WIDTH must be >= 1");
  end

  state_t                     state_q, state_d;
  logic [ADDRESS_WIDTH_I-1:0] i_q, i_d, num_i_q, num_i_d;
  logic [ADDRESS_WIDTH_K-1:0] k_q, k_d, num_k_q, num_k_d;
  logic [CW-1:0]              credits_q, credits_d;
  logic [CW-1:0]              inflight_q, inflight_d;
  logic                       credit_err_q, credit_err_d;

  logic issue;
  logic mac_take;
  logic last_i;
  logic last_k;
  logic at_max;

  // Decode helpers from registered state
  always_comb begin
    issue    = (state_q == S_RUN) && (credits_q != {CW{1'b0}});
    mac_take = mac_val_out && (inflight_q != {CW{1'b0}});
    last_i   = (i_q == (num_i_q - ADDRESS_WIDTH_I'(1)));
    last_k   = (k_q == (num_k_q - ADDRESS_WIDTH_K'(1)));
    at_max   = (credits_q == CW'(CREDIT_DEPTH));
  end

  // Credit and in-flight bookkeeping; stray returns or results latch the error flag
  always_comb begin
    case ({issue, mac_take})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    case ({issue, credit_return})
      2'b10: credits_d = credits_q - CW'(1);
      2'b01: begin
        if (at_max) begin
          credits_d = credits_q;
        end else begin
          credits_d = credits_q + CW'(1);
        end
      end
      default: credits_d = credits_q;
    endcase

    credit_err_d = credit_err_q
                 | (credit_return & ~issue & at_max)
                 | (mac_val_out & (inflight_q == {CW{1'b0}}));
  end

  // Job FSM and row-major index walk (k inner, i outer)
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    k_d     = k_q;
    num_i_d = num_i_q;
    num_k_d = num_k_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_i_d = cfg_num_i;
          num_k_d = cfg_num_k;
          i_d     = {ADDRESS_WIDTH_I{1'b0}};
          k_d     = {ADDRESS_WIDTH_K{1'b0}};
          if ((cfg_num_i == {ADDRESS_WIDTH_I{1'b0}}) || (cfg_num_k == {ADDRESS_WIDTH_K{1'b0}})) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (issue) begin
          if (last_k) begin
            // The final pair leaves the counters parked on it
            if (last_i) begin
              state_d = S_DRAIN;
            end else begin
              i_d = i_q + ADDRESS_WIDTH_I'(1);
              k_d = {ADDRESS_WIDTH_K{1'b0}};
            end
          end else begin
            k_d = k_q + ADDRESS_WIDTH_K'(1);
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (inflight_d == {CW{1'b0}}) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      i_q          <= {ADDRESS_WIDTH_I{1'b0}};
      k_q          <= {ADDRESS_WIDTH_K{1'b0}};
      num_i_q      <= {ADDRESS_WIDTH_I{1'b0}};
      num_k_q      <= {ADDRESS_WIDTH_K{1'b0}};
      credits_q    <= CW'(CREDIT_DEPTH);
      inflight_q   <= {CW{1'b0}};
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      k_q          <= k_d;
      num_i_q      <= num_i_d;
      num_k_q      <= num_k_d;
      credits_q    <= credits_d;
      inflight_q   <= inflight_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done         = (state_q == S_DONE);
  assign issue_val    = issue;
  assign issue_addr_i = i_q;
  assign issue_addr_k = k_q;
  assign credit_err   = credit_err_q;

`ifdef TREE_MAC_SCHED_STALL_CNT_EN
  logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;

  // Saturating count of credit-starved RUN cycles, cleared by an accepted start
  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_IDLE) && start) begin
      stall_d = {STALL_CNT_WIDTH{1'b0}};
    end else if ((state_q == S_RUN) && (credits_q == {CW{1'b0}})
                 && (stall_q != {STALL_CNT_WIDTH{1'b1}})) begin
      stall_d = stall_q + STALL_CNT_WIDTH'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= {STALL_CNT_WIDTH{1'b0}};
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_tree_mac_job_scheduler.sv
// Randomized/directed bench for tree_mac_job_scheduler against a queue-based reference model.
module tb_tree_mac_job_scheduler;
  localparam int AW_I  = 8;
  localparam int AW_K  = 8;
  localparam int DEPTH = 8;
  localparam int SW    = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [AW_I-1:0] cfg_num_i = '0;
  logic [AW_K-1:0] cfg_num_k = '0;
  logic            mac_val_out = 1'b0;
  logic            credit_return = 1'b0;
  logic            busy, done, issue_val, credit_err;
  logic [AW_I-1:0] issue_addr_i;
  logic [AW_K-1:0] issue_addr_k;
`ifdef TREE_MAC_SCHED_STALL_CNT_EN
  logic [SW-1:0]   stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    int n_issue, seq_err, iv_err, busy_err, done_err, n_done, stall;
    int last_ai, last_ak, first_issue, last_issue, done_cyc, last_mac_cyc, before_gate;
    bit timeout;
  } job_stats_t;

  always #5 clk = ~clk;

  tree_mac_job_scheduler #(
    .ADDRESS_WIDTH_I(AW_I), .ADDRESS_WIDTH_K(AW_K), .CREDIT_DEPTH(DEPTH), .STALL_CNT_WIDTH(SW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_num_i(cfg_num_i), .cfg_num_k(cfg_num_k),
    .busy(busy), .done(done), .issue_val(issue_val), .issue_addr_i(issue_addr_i),
    .issue_addr_k(issue_addr_k), .mac_val_out(mac_val_out), .credit_return(credit_return),
    .credit_err(credit_err)
`ifdef TREE_MAC_SCHED_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  // Runs one job. The environment models the MAC as a lat-cycle delay line and
  // returns one credit per result from cycle 'gate' on. Reference: expected (i,k)
  // list in row-major order, credit counter and outstanding-result count.
  task automatic run_job(input int ni, input int nk, input int lat, input int gate,
                         input int rs1, input int rs2, output job_stats_t st);
    logic [AW_I-1:0] q_i[$];
    logic [AW_K-1:0] q_k[$];
    bit pipe[$];
    int credits = DEPTH;
    int inflight = 0;
    int pending = 0;
    bit m_busy = 1'b0, m_done = 1'b0, exp_iv, mac_now, cr, fin = 1'b0;
    int c = 0;
    int bound = ni * nk * 4 + lat + gate + 100;
    st = '{default: 0};
    st.first_issue = -1; st.done_cyc = -1; st.last_mac_cyc = -1;
    for (int ii = 0; ii < ni; ii++)
      for (int kk = 0; kk < nk; kk++) begin
        q_i.push_back(AW_I'(ii));
        q_k.push_back(AW_K'(kk));
      end
    for (int l = 0; l < lat; l++) pipe.push_back(1'b0);
    while (!fin) begin
      @(negedge clk);
      exp_iv = m_busy && (q_i.size() > 0) && (credits != 0);
      if (issue_val !== exp_iv) st.iv_err++;
      if (busy !== m_busy) st.busy_err++;
      if (done !== m_done) st.done_err++;
      if (done === 1'b1) begin st.n_done++; st.done_cyc = c; end
      if (issue_val === 1'b1) begin
        st.n_issue++;
        if (st.first_issue < 0) st.first_issue = c;
        st.last_issue = c;
        st.last_ai = int'(issue_addr_i);
        st.last_ak = int'(issue_addr_k);
        if (c < gate) st.before_gate++;
        if (exp_iv && ((issue_addr_i !== q_i[0]) || (issue_addr_k !== q_k[0]))) st.seq_err++;
      end
      if (m_busy && (q_i.size() > 0) && (credits == 0)) st.stall++;
      mac_now = pipe.pop_front();
      pipe.push_back(issue_val === 1'b1);
      if (mac_now) st.last_mac_cyc = c;
      pending += int'(mac_now);
      cr = (c >= gate) && (pending > 0);
      if (cr) pending--;
      start = (c == 0) || (c == rs1) || (c == rs2);
      cfg_num_i = (c == 0) ? AW_I'(ni) : AW_I'(1);
      cfg_num_k = (c == 0) ? AW_K'(nk) : AW_K'(1);
      mac_val_out = mac_now;
      credit_return = cr;
      // reference update for the coming edge
      m_done = 1'b0;
      if (c == 0) begin
        if (q_i.size() == 0) m_done = 1'b1;
        else m_busy = 1'b1;
      end else if (m_busy) begin
        if (mac_now && inflight > 0) inflight--;
        if (exp_iv) begin void'(q_i.pop_front()); void'(q_k.pop_front()); inflight++; end
        if (q_i.size() == 0 && inflight == 0) begin m_busy = 1'b0; m_done = 1'b1; end
      end
      credits = credits - int'(exp_iv) + int'(cr);
      if (credits > DEPTH) credits = DEPTH;
      c++;
      if (st.n_done > 0 && pending == 0 && !m_busy && !m_done) fin = 1'b1;
      if (c > bound) begin st.timeout = 1'b1; fin = 1'b1; end
    end
    @(negedge clk);
    start = 1'b0; mac_val_out = 1'b0; credit_return = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (issue_val !== 1'b0) begin bad++; $display("FAIL reset_issue got=%b exp=0", issue_val); end
    total++; if ({issue_addr_i, issue_addr_k} !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h exp=0", {issue_addr_i, issue_addr_k}); end
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL reset_cerr got=%b exp=0", credit_err); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    job_stats_t st;
    run_job(2, 3, 8, 0, -1, -1, st);
    total++; if (st.timeout) begin bad++; $display("FAIL basic_timeout got=1 exp=0"); end
    total++; if (st.n_issue !== 6) begin bad++; $display("FAIL basic_issues got=%0d exp=6", st.n_issue); end
    total++; if (st.seq_err !== 0) begin bad++; $display("FAIL basic_order errs=%0d exp=0", st.seq_err); end
    total++; if (st.first_issue !== 1 || st.last_issue !== 6) begin bad++; $display("FAIL basic_consecutive first=%0d last=%0d exp=1,6", st.first_issue, st.last_issue); end
    total++; if (st.done_cyc !== st.last_mac_cyc + 1) begin bad++; $display("FAIL basic_done_cycle got=%0d exp=%0d", st.done_cyc, st.last_mac_cyc + 1); end
    total++; if (st.busy_err !== 0 || st.done_err !== 0 || st.iv_err !== 0) begin bad++; $display("FAIL basic_ctrl busy=%0d done=%0d iv=%0d exp=0", st.busy_err, st.done_err, st.iv_err); end
    total++; if (st.n_done !== 1) begin bad++; $display("FAIL basic_done_count got=%0d exp=1", st.n_done); end
  endtask

  task automatic test_empty();
    job_stats_t st;
    run_job(0, 5, 8, 0, -1, -1, st);
    total++; if (st.n_issue !== 0) begin bad++; $display("FAIL empty_issues got=%0d exp=0", st.n_issue); end
    total++; if (st.done_cyc !== 1) begin bad++; $display("FAIL empty_done_cycle got=%0d exp=1", st.done_cyc); end
    total++; if (st.busy_err !== 0 || st.n_done !== 1) begin bad++; $display("FAIL empty_ctrl busy_err=%0d ndone=%0d exp=0,1", st.busy_err, st.n_done); end
  endtask

  task automatic test_credit_stall();
    job_stats_t st;
    run_job(1, 12, 8, 20, -1, -1, st);
    total++; if (st.before_gate !== DEPTH) begin bad++; $display("FAIL stall_first_burst got=%0d exp=%0d", st.before_gate, DEPTH); end
    total++; if (st.n_issue !== 12) begin bad++; $display("FAIL stall_issues got=%0d exp=12", st.n_issue); end
    total++; if (st.iv_err !== 0 || st.seq_err !== 0) begin bad++; $display("FAIL stall_flow iv=%0d seq=%0d exp=0", st.iv_err, st.seq_err); end
`ifdef TREE_MAC_SCHED_STALL_CNT_EN
    total++; if (stall_cycles !== SW'(12)) begin bad++; $display("FAIL stall_cnt got=%0d exp=12", stall_cycles); end
`endif
  endtask

  task automatic test_simultaneous();
    int iss = 0, iss_prior, ret = 1, macs = 0, nd = 0;
    bit ivh[0:10];
    @(negedge clk);
    start = 1'b1; cfg_num_i = AW_I'(1); cfg_num_k = AW_K'(10);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      ivh[c] = issue_val;
      if (issue_val === 1'b1) iss++;
      credit_return = (c == 8);
    end
    total++; if (ivh[8] !== 1'b1 || ivh[9] !== 1'b1) begin bad++; $display("FAIL simul_issue got=%b%b exp=11", ivh[8], ivh[9]); end
    total++; if (ivh[10] !== 1'b0 || iss !== 9) begin bad++; $display("FAIL simul_stop iv=%b iss=%0d exp=0,9", ivh[10], iss); end
    iss_prior = iss;
    for (int n = 0; n < 80 && !(nd > 0 && ret == iss); n++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
      if (issue_val === 1'b1) iss++;
      mac_val_out = (macs < iss_prior);
      if (mac_val_out) macs++;
      credit_return = (ret < iss);
      if (credit_return) ret++;
      iss_prior = iss;
    end
    @(negedge clk);
    mac_val_out = 1'b0; credit_return = 1'b0;
    total++; if (nd !== 1 || iss !== 10) begin bad++; $display("FAIL simul_finish ndone=%0d iss=%0d exp=1,10", nd, iss); end
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL cerr_before got=%b exp=0", credit_err); end
    credit_return = 1'b1;
    @(negedge clk);
    credit_return = 1'b0;
    total++; if (credit_err !== 1'b1) begin bad++; $display("FAIL cerr_set got=%b exp=1", credit_err); end
    repeat (3) @(negedge clk);
    total++; if (credit_err !== 1'b1) begin bad++; $display("FAIL cerr_sticky got=%b exp=1", credit_err); end
  endtask

  task automatic test_ignore_and_reset();
    job_stats_t st;
    run_job(2, 4, 6, 0, 3, 11, st);
    total++; if (st.n_issue !== 8 || st.seq_err !== 0) begin bad++; $display("FAIL ignore_start iss=%0d seq=%0d exp=8,0", st.n_issue, st.seq_err); end
    total++; if (st.n_done !== 1 || st.done_err !== 0 || st.iv_err !== 0) begin bad++; $display("FAIL ignore_ctrl ndone=%0d derr=%0d iverr=%0d exp=1,0,0", st.n_done, st.done_err, st.iv_err); end
    @(negedge clk);
    start = 1'b1; cfg_num_i = AW_I'(3); cfg_num_k = AW_K'(3);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if ({busy, done, issue_val, credit_err} !== 4'b0000) begin bad++; $display("FAIL midreset_ctrl got=%b exp=0000", {busy, done, issue_val, credit_err}); end
    total++; if ({issue_addr_i, issue_addr_k} !== 16'h0000) begin bad++; $display("FAIL midreset_addr got=%h exp=0", {issue_addr_i, issue_addr_k}); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_job(1, 1, 4, 0, -1, -1, st);
    total++; if (st.n_issue !== 1 || st.n_done !== 1 || st.done_err !== 0) begin bad++; $display("FAIL after_reset_job iss=%0d ndone=%0d derr=%0d exp=1,1,0", st.n_issue, st.n_done, st.done_err); end
    run_job(1, 9, 12, 0, -1, -1, st);
    total++; if (st.iv_err !== 0 || st.n_issue !== 9) begin bad++; $display("FAIL after_reset_credits iverr=%0d iss=%0d exp=0,9", st.iv_err, st.n_issue); end
  endtask

  task automatic test_wrap();
    job_stats_t st;
    run_job(255, 255, 3, 0, -1, -1, st);
    total++; if (st.n_issue !== 65025 || st.timeout) begin bad++; $display("FAIL wrap_issues got=%0d exp=65025 timeout=%0d", st.n_issue, st.timeout); end
    total++; if (st.last_ai !== 254 || st.last_ak !== 254) begin bad++; $display("FAIL wrap_last got=(%0d,%0d) exp=(254,254)", st.last_ai, st.last_ak); end
    total++; if (st.seq_err !== 0 || st.n_done !== 1) begin bad++; $display("FAIL wrap_order seq=%0d ndone=%0d exp=0,1", st.seq_err, st.n_done); end
  endtask

  task automatic test_random();
    job_stats_t st;
    int ni, nk, lat, gate;
    for (int j = 0; j < 6; j++) begin
      ni = int'($urandom_range(0, 6));
      nk = int'($urandom_range(0, 6));
      lat = int'($urandom_range(1, 12));
      gate = int'($urandom_range(0, 15));
      run_job(ni, nk, lat, gate, -1, -1, st);
      total++; if (st.n_issue !== ni * nk || st.seq_err !== 0) begin bad++; $display("FAIL rand_job%0d iss=%0d exp=%0d seq=%0d", j, st.n_issue, ni * nk, st.seq_err); end
      total++; if (st.iv_err !== 0 || st.busy_err !== 0 || st.done_err !== 0 || st.n_done !== 1 || st.timeout) begin bad++; $display("FAIL rand_ctrl%0d iv=%0d busy=%0d done=%0d ndone=%0d to=%0d", j, st.iv_err, st.busy_err, st.done_err, st.n_done, st.timeout); end
`ifdef TREE_MAC_SCHED_STALL_CNT_EN
      total++; if (stall_cycles !== SW'(st.stall)) begin bad++; $display("FAIL rand_stall%0d got=%0d exp=%0d", j, stall_cycles, st.stall); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_credit_stall();
    test_simultaneous();
    test_ignore_and_reset();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
